// File: rtl/ifetch_cache_pkg.sv
// Shared core definitions for the instruction-fetch cache: the NOP
// instruction injected on stalls and the fill FSM state encoding.
package ifetch_cache_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_cache_array.sv
// Tag and data storage for the direct-mapped fetch cache.
// One combinational read port for lookup, one synchronous write port for fills.
// Contents are not reset; validity is tracked by the owner of this array.
module icache_array #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Fill write: tag and word land together in the indexed line.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_tag_o  = tag_q[rd_idx_i];
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/ifetch_cache.sv
// Direct-mapped, one-word-per-line instruction fetch cache.
// Hits return data in the same cycle; misses stall the core, issue a single
// word read and refill the line. A flush during an outstanding read lets the
// read finish but discards its data so stale code is never validated.
module ifetch_cache
    import ifetch_cache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_iaddr,
    output logic [31:0] o_inst,
    output logic        o_stall,
    input  logic        i_flush,
    output logic        o_mreq,
    output logic [31:0] o_maddr,
    input  logic        i_mack,
    input  logic [31:0] i_mdata
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    fetch_state_e     state_q;
    logic [LINES-1:0] valid_q;
    logic             drop_q;
    logic             mreq_q;
    logic [31:0]      maddr_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             fill_we;
    logic             unused_addr_lsb;

    assign req_idx  = i_iaddr[IDX_W+1:2];
    assign req_tag  = i_iaddr[31:IDX_W+2];
    assign fill_idx = maddr_q[IDX_W+1:2];
    assign fill_tag = maddr_q[31:IDX_W+2];
    assign unused_addr_lsb = ^i_iaddr[1:0];

    assign hit     = (state_q == ST_IDLE) && valid_q[req_idx] && (rd_tag == req_tag) && !i_flush;
    // A flush in the same cycle as the acknowledge also kills the write.
    assign fill_we = (state_q == ST_REQ) && i_mack && !drop_q && !i_flush;

    assign o_inst  = hit ? rd_data : NOP;
    assign o_stall = !hit;
    assign o_mreq  = mreq_q;
    assign o_maddr = maddr_q;

    icache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .rd_idx_i  (req_idx),
        .rd_tag_o  (rd_tag),
        .rd_data_o (rd_data),
        .wr_en_i   (fill_we),
        .wr_idx_i  (fill_idx),
        .wr_tag_i  (fill_tag),
        .wr_data_i (i_mdata)
    );

    // Miss/fill sequencing, valid bits and registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            drop_q  <= 1'b0;
            mreq_q  <= 1'b0;
            maddr_q <= '0;
        end else begin
            if (i_flush) begin
                valid_q <= '0;
            end else if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    drop_q <= 1'b0;
                    if (!hit && !i_flush) begin
                        maddr_q <= {i_iaddr[31:2], 2'b00};
                        mreq_q  <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (i_mack) begin
                        mreq_q  <= 1'b0;
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    drop_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    mreq_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_cache.sv
// Self-checking bench for ifetch_cache: directed scenarios plus a randomized
// run compared against a line-level behavioural model.
module tb_ifetch_cache;

    localparam logic [31:0] NOP_I = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_iaddr;
    logic [31:0] o_inst;
    logic        o_stall;
    logic        i_flush;
    logic        o_mreq;
    logic [31:0] o_maddr;
    logic        i_mack;
    logic [31:0] i_mdata;

    int checks = 0;
    int failures = 0;

    ifetch_cache #(.LINES(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_iaddr (i_iaddr),
        .o_inst  (o_inst),
        .o_stall (o_stall),
        .i_flush (i_flush),
        .o_mreq  (o_mreq),
        .o_maddr (o_maddr),
        .i_mack  (i_mack),
        .i_mdata (i_mdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_flush = 1'b0; i_mack = 1'b0; i_mdata = '0; i_iaddr = '0;
        step(); step();
        rst = 1'b0;
    endtask

    // Stimulus only: miss on addr, acknowledge in the first REQ cycle, finish FILL.
    task automatic fill(input logic [31:0] addr, input logic [31:0] data);
        i_iaddr = addr; i_mack = 1'b0; i_flush = 1'b0;
        step();
        i_mack = 1'b1; i_mdata = data;
        step();
        i_mack = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; i_flush = 1'b0; i_mack = 1'b0; i_mdata = '0; i_iaddr = '0;
        step(); step();
        checks++; if (o_mreq !== 1'b0) begin failures++; $display("FAIL reset_mreq got=%b exp=0", o_mreq); end
        checks++; if (o_maddr !== 32'h0) begin failures++; $display("FAIL reset_maddr got=%h exp=0", o_maddr); end
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", o_stall); end
        checks++; if (o_inst !== NOP_I) begin failures++; $display("FAIL reset_inst got=%h exp=%h", o_inst, NOP_I); end
        rst = 1'b0;
    endtask

    task automatic test_first_fill();
        do_reset();
        i_iaddr = 32'h0; #1;
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL ff_miss_stall got=%b exp=1", o_stall); end
        checks++; if (o_mreq !== 1'b0) begin failures++; $display("FAIL ff_miss_mreq got=%b exp=0", o_mreq); end
        step();
        i_mack = 1'b1; i_mdata = 32'h00500093; #1;
        checks++; if (o_mreq !== 1'b1) begin failures++; $display("FAIL ff_req_mreq got=%b exp=1", o_mreq); end
        checks++; if (o_maddr !== 32'h0) begin failures++; $display("FAIL ff_req_maddr got=%h exp=0", o_maddr); end
        step();
        i_mack = 1'b0; #1;
        checks++; if (o_mreq !== 1'b0) begin failures++; $display("FAIL ff_fill_mreq got=%b exp=0", o_mreq); end
        checks++; if (o_stall !== 1'b1 || o_inst !== NOP_I) begin failures++; $display("FAIL ff_fill_stall got=%b/%h exp=1/%h", o_stall, o_inst, NOP_I); end
        step();
        checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL ff_hit_stall got=%b exp=0", o_stall); end
        checks++; if (o_inst !== 32'h00500093) begin failures++; $display("FAIL ff_hit_inst got=%h exp=00500093", o_inst); end
    endtask

    task automatic test_hit();
        do_reset();
        fill(32'h100, 32'hCAFE0113);
        i_iaddr = 32'h100; #1;
        checks++; if (o_stall !== 1'b0 || o_inst !== 32'hCAFE0113) begin failures++; $display("FAIL hit_same got=%b/%h exp=0/cafe0113", o_stall, o_inst); end
        step();
        checks++; if (o_mreq !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL hit_nomreq got=%b/%b exp=0/0", o_mreq, o_stall); end
    endtask

    task automatic test_conflict();
        do_reset();
        fill(32'h004, 32'hAAAA0001);
        i_iaddr = 32'h044; #1;
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL conf_miss got=%b exp=1", o_stall); end
        step();
        checks++; if (o_mreq !== 1'b1 || o_maddr !== 32'h044) begin failures++; $display("FAIL conf_maddr got=%b/%h exp=1/00000044", o_mreq, o_maddr); end
        i_mack = 1'b1; i_mdata = 32'hBBBB0002;
        step();
        i_mack = 1'b0;
        step();
        checks++; if (o_stall !== 1'b0 || o_inst !== 32'hBBBB0002) begin failures++; $display("FAIL conf_newhit got=%b/%h exp=0/bbbb0002", o_stall, o_inst); end
        i_iaddr = 32'h004; #1;
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL conf_oldmiss got=%b exp=1", o_stall); end
        step();
        checks++; if (o_maddr !== 32'h004) begin failures++; $display("FAIL conf_oldmaddr got=%h exp=00000004", o_maddr); end
    endtask

    task automatic test_wait();
        do_reset();
        i_iaddr = 32'h200;
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (o_mreq !== 1'b1 || o_maddr !== 32'h200 || o_stall !== 1'b1 || o_inst !== NOP_I) begin
                failures++;
                $display("FAIL wait_hold[%0d] got=%b/%h/%b/%h exp=1/00000200/1/%h", k, o_mreq, o_maddr, o_stall, o_inst, NOP_I);
            end
            step();
        end
        i_mack = 1'b1; i_mdata = 32'h12345678;
        step();
        i_mack = 1'b0;
        step();
        checks++; if (o_stall !== 1'b0 || o_inst !== 32'h12345678) begin failures++; $display("FAIL wait_hit got=%b/%h exp=0/12345678", o_stall, o_inst); end
    endtask

    task automatic test_flush_req();
        do_reset();
        i_iaddr = 32'h300;
        step();
        step();
        i_flush = 1'b1; #1;
        checks++; if (o_stall !== 1'b1 || o_mreq !== 1'b1) begin failures++; $display("FAIL fl_req got=%b/%b exp=1/1", o_stall, o_mreq); end
        step();
        i_flush = 1'b0; i_mack = 1'b1; i_mdata = 32'h0000DEAD;
        step();
        i_mack = 1'b0;
        step();
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL fl_dropped got=%b exp=1", o_stall); end
        step();
        checks++; if (o_mreq !== 1'b1 || o_maddr !== 32'h300) begin failures++; $display("FAIL fl_remiss got=%b/%h exp=1/00000300", o_mreq, o_maddr); end
        // Same again with flush and acknowledge coincident.
        do_reset();
        i_iaddr = 32'h400;
        step();
        i_flush = 1'b1; i_mack = 1'b1; i_mdata = 32'h0000BEEF;
        step();
        i_flush = 1'b0; i_mack = 1'b0;
        step();
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL fl_coinc got=%b exp=1", o_stall); end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        i_iaddr = 32'h500;
        step();
        checks++; if (o_mreq !== 1'b1) begin failures++; $display("FAIL rmid_req got=%b exp=1", o_mreq); end
        rst = 1'b1;
        step();
        rst = 1'b0; i_mack = 1'b1; i_mdata = 32'h0000F00D; #1;
        checks++; if (o_mreq !== 1'b0) begin failures++; $display("FAIL rmid_mreq got=%b exp=0", o_mreq); end
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL rmid_valid got=%b exp=1", o_stall); end
        step();
        i_mack = 1'b0;
        // Late acknowledge landed in IDLE; it must not have filled the line.
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL rmid_late got=%b exp=1", o_stall); end
    endtask

    // Randomized run against a line-level model of the cache contents.
    task automatic test_random();
        logic [31:0] pool [8];
        bit          m_valid [16];
        logic [31:0] m_addr  [16];
        logic [31:0] m_data  [16];
        int          m_phase;     // 0 lookup, 1 waiting for memory, 2 refill bubble
        bit          m_drop;
        logic [31:0] m_maddr;
        logic [31:0] wa;
        int          idx;
        bit          exp_hit;
        logic [31:0] exp_inst;

        pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0040; pool[2] = 32'h0000_0004;
        pool[3] = 32'h0000_0104; pool[4] = 32'h0000_0008; pool[5] = 32'h0000_1000;
        pool[6] = 32'h0000_000C; pool[7] = 32'hFFFF_FFFC;
        for (int j = 0; j < 16; j++) begin m_valid[j] = 0; m_addr[j] = '0; m_data[j] = '0; end
        m_phase = 0; m_drop = 0; m_maddr = '0;
        do_reset();
        i_iaddr = pool[0];
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)
                i_iaddr = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            i_flush = ($urandom_range(0, 11) == 0);
            i_mack  = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            i_mdata = $urandom;
            #1;
            wa  = {i_iaddr[31:2], 2'b00};
            idx = int'((wa / 4) % 16);
            exp_hit  = (m_phase == 0) && m_valid[idx] && (m_addr[idx] == wa) && !i_flush;
            exp_inst = exp_hit ? m_data[idx] : NOP_I;
            checks++; if (o_inst !== exp_inst) begin failures++; $display("FAIL rnd_inst c=%0d got=%h exp=%h", c, o_inst, exp_inst); end
            checks++; if (o_stall !== !exp_hit) begin failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, o_stall, !exp_hit); end
            checks++; if (o_mreq !== (m_phase == 1)) begin failures++; $display("FAIL rnd_mreq c=%0d got=%b exp=%b", c, o_mreq, m_phase == 1); end
            checks++; if (o_maddr !== m_maddr) begin failures++; $display("FAIL rnd_maddr c=%0d got=%h exp=%h", c, o_maddr, m_maddr); end

            if (i_flush)
                for (int j = 0; j < 16; j++) m_valid[j] = 0;
            if (m_phase == 0) begin
                if (!exp_hit && !i_flush) begin
                    m_maddr = wa;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (i_flush) m_drop = 1;
                if (i_mack) begin
                    if (!m_drop) begin
                        m_valid[(m_maddr / 4) % 16] = 1;
                        m_addr[(m_maddr / 4) % 16]  = m_maddr;
                        m_data[(m_maddr / 4) % 16]  = i_mdata;
                    end
                    m_phase = 2;
                end
            end else begin
                m_phase = 0;
                m_drop  = 0;
            end
            step();
        end
        i_flush = 1'b0; i_mack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_hit();
        test_conflict();
        test_wait();
        test_flush_req();
        test_reset_mid_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_cache.md
IFETCH_CACHE -- requirements
Module: ifetch_cache

Interface
REQ-001 LINES, 16, number of direct-mapped one-word lines; power of two, 4..256.
REQ-002 NOP, 32'h00000013, instruction driven to the core on any non-hit cycle.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_iaddr  in  32  fetch address from the core PC.
REQ-006 o_inst  out  32  instruction to the core.
REQ-007 o_stall  out  1  stall to the core's external-stall input; 1 = hold PC.
REQ-008 i_flush  in  1  invalidate all lines (fence.i / self-modifying code).
REQ-009 o_mreq  out  1  memory read request.
REQ-010 o_maddr  out  32  memory word address; bits [1:0] = 0.
REQ-011 i_mack  in  1  memory acknowledge; i_mdata valid in the same cycle.
REQ-012 i_mdata  in  32  memory read data.

Function
REQ-013 Address split SHALL be: bits [1:0] ignored, index = next log2(LINES) bits, tag = remaining upper bits.
REQ-014 Each line SHALL hold a valid bit, a tag and a 32-bit word.
REQ-015 hit SHALL be combinational: state IDLE, valid[index] set, stored tag equal to the address tag, and i_flush low.
REQ-016 On hit, o_inst SHALL be data[index] and o_stall 0 in the same cycle (zero-latency hit).
REQ-017 On any non-hit cycle, o_inst SHALL be NOP and o_stall 1.
REQ-018 FSM states SHALL be IDLE, REQ and FILL.
REQ-019 IDLE on miss (i_flush low) SHALL latch {i_iaddr[31:2],2'b00} into o_maddr and go to REQ.
REQ-020 In REQ, o_mreq SHALL be 1 and o_maddr stable until i_mack is sampled high.
REQ-021 REQ with i_mack high SHALL write the latched tag and i_mdata into the indexed line, set its valid bit, deassert o_mreq next cycle and go to FILL.
REQ-022 FILL SHALL last exactly one cycle with o_stall 1, then return to IDLE.
REQ-023 Miss latency: with i_mack in the first REQ cycle, the hit SHALL occur 3 cycles after the miss cycle (miss, REQ, FILL, hit).
REQ-024 On IDLE re-entry, lookup SHALL use the current i_iaddr; a changed address is a new miss.
REQ-025 i_flush SHALL clear all valid bits at the next edge and force o_stall 1 in its own cycle.
REQ-026 i_flush in REQ SHALL set a drop flag; the transaction still completes on i_mack, but the line SHALL NOT be written or validated.
REQ-027 i_flush coincident with i_mack SHALL drop the fill (flush wins).
REQ-028 i_mack outside REQ SHALL be ignored.
REQ-029 o_mreq SHALL never be asserted in IDLE or FILL.
REQ-030 The drop flag SHALL clear on entry to IDLE.

Reset
REQ-031 Reset SHALL clear all valid bits and the drop flag and force state IDLE.
REQ-032 Reset values: o_mreq 0, o_maddr 0, o_stall 1, o_inst NOP.
REQ-033 Reset mid-REQ SHALL abandon the transaction and deassert o_mreq at the next edge; a late i_mack SHALL be ignored.
REQ-034 Tag and data arrays SHALL NOT require reset.

Structure
REQ-035 The NOP constant and the FSM state encoding SHALL live in the shared core package.
REQ-036 Tag/data storage SHALL be a sub-module icache_array: one combinational read port, one synchronous write port.
REQ-037 Valid bits SHALL be flops in ifetch_cache, never inside icache_array.

Verification
REQ-038 Reset, then i_iaddr=0x00000000, i_mack in the first REQ cycle with i_mdata=0x00500093 -> o_mreq for one cycle, o_maddr=0x0, o_inst=0x00500093 with o_stall 0 three cycles after the miss.
REQ-039 Fill 0x100, then fetch 0x100 again -> hit with o_stall 0 in the same cycle, no o_mreq.
REQ-040 Fill 0x004, then fetch 0x044 (same index for LINES=16, different tag) -> miss, o_maddr=0x044, line replaced; a following fetch of 0x004 misses again.
REQ-041 i_mack held off for 5 REQ cycles -> o_mreq and o_maddr stable for all 5, o_stall 1 throughout, o_inst NOP.
REQ-042 i_flush in the second REQ cycle, then i_mack -> line not valid, fetch of the same address re-misses; i_flush and i_mack in the same cycle -> same result.
REQ-043 rst asserted mid-REQ, then i_mack one cycle later -> o_mreq 0 after the edge, no line valid, state IDLE.
